shift_sequencer: RTL and testbench

Multi-cycle controller for the RISC core's shift unit. It accepts one shift request at a time over a valid/ready handshake and performs logical, arithmetic and rotate shifts iteratively, at most STEP bit positions per cycle. It returns the result over a second valid/ready handshake. It sits between the decode/issue stage and the writeback mux, replacing the single-cycle barrel shifter when area is constrained.

---
 rtl/shift_defs.sv | 32 +++
 rtl/shift_step.sv | 39 +++
 rtl/shift_sequencer.sv | 95 +++++++++
 tb/tb_shift_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_defs.sv
// Shared op-code and state definitions for the shift unit family.
// The barrel shifter and the decoder use the same op-code set.
package shift_defs;

  localparam int SHW = 5;

  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_LSL  = 4'b1010;
  localparam logic [3:0] OP_ASR  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam logic [3:0] OP_ROL  = 4'b1101;
  localparam logic [3:0] OP_PASS = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_LSR, OP_LSL, OP_ASR, OP_ROR, OP_ROL, OP_PASS: ok = 1'b1;
      default:                                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Ops that need the iterative RUN phase (everything legal except PASS).
  function automatic logic op_iter(input logic [3:0] op);
    return op_legal(op) && (op != OP_PASS);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the shift unit: shifts or rotates the accumulator by k.
// k never exceeds STEP, so each op is a small bounded shifter.
module shift_step
  import shift_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [KW-1:0]    i_k,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_dbl;
  logic [2*WIDTH-1:0] w_ror;
  logic [2*WIDTH-1:0] w_rol;
  logic [WIDTH-1:0]   w_asr;

  // Rotating a doubled copy avoids a separate wrap-around term.
  assign w_dbl = {i_acc, i_acc};
  assign w_ror = w_dbl >> i_k;
  assign w_rol = w_dbl << i_k;
  assign w_asr = $signed(i_acc) >>> i_k;

  always_comb begin
    o_acc = i_acc;
    case (i_op)
      OP_LSR:  o_acc = i_acc >> i_k;
      OP_LSL:  o_acc = i_acc << i_k;
      OP_ASR:  o_acc = w_asr;
      OP_ROR:  o_acc = w_ror[WIDTH-1:0];
      OP_ROL:  o_acc = w_rol[2*WIDTH-1:WIDTH];
      default: o_acc = i_acc;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shift controller: accepts one request, shifts up to STEP bits
// per cycle, then holds the result until the consumer takes it.
module shift_sequencer
  import shift_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [SHW-1:0]   req_sh,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  localparam int          KW     = $clog2(STEP) + 1;
  localparam logic [31:0] STEP_U = 32'(STEP);

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [SHW-1:0]   r_rem;
  logic [WIDTH-1:0] r_acc;
  logic             r_err;

  logic [KW-1:0]    w_k;
  logic [SHW-1:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_step_acc;

  // k = min(rem, STEP); compared at 32 bits so STEP=WIDTH never truncates.
  always_comb begin
    w_k = KW'(STEP_U);
    if (32'(r_rem) < STEP_U) w_k = KW'(r_rem);
  end

  assign w_rem_nxt = r_rem - SHW'(w_k);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .i_acc (r_acc),
    .i_k   (w_k),
    .i_op  (r_op),
    .o_acc (w_step_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_rem   <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_rem   <= req_sh;
            r_acc   <= req_data;
            r_err   <= !op_legal(req_op);
            r_state <= (op_iter(req_op) && (req_sh != '0)) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          r_acc <= w_step_acc;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == '0) r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_data  = r_acc;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, reset corner cases and
// a randomized sweep against a whole-amount arithmetic reference model.
module tb_shift_sequencer;
  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_op = '0;
  logic [4:0]       req_sh = '0;
  logic [WIDTH-1:0] req_data = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  shift_sequencer #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sh(req_sh), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  // Reference model: whole-amount arithmetic, no stepping.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [4:0] sh, input logic [31:0] d);
    logic [63:0] t;
    case (op)
      4'b1001: return d >> sh;
      4'b1010: return d << sh;
      4'b1011: return 32'($signed(d) >>> sh);
      4'b1100: begin t = {d, d} >> sh; return t[31:0]; end
      4'b1101: begin t = {d, d} << sh; return t[63:32]; end
      default: return d;
    endcase
  endfunction

  function automatic logic ref_err(input logic [3:0] op);
    return !(op inside {4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111});
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [4:0] sh);
    if (ref_err(op) || op == 4'b1111) return 0;
    return (int'(sh) + STEP - 1) / STEP;
  endfunction

  task automatic check_reset_vals(input string nm);
    chk(nm, "req_ready", 32'(req_ready), 32'd1);
    chk(nm, "rsp_valid", 32'(rsp_valid), 32'd0);
    chk(nm, "rsp_data",  rsp_data,       32'd0);
    chk(nm, "rsp_err",   32'(rsp_err),   32'd0);
    chk(nm, "busy",      32'(busy),      32'd0);
  endtask

  // One full transaction; req_* is scrambled while the block is running.
  task automatic run_txn(input string nm, input logic [3:0] op, input logic [4:0] sh,
                         input logic [31:0] d, input logic [31:0] e_d, input logic e_err,
                         input int e_lat, input int hold);
    int g;
    int lat;
    @(negedge clk);
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    chk(nm, "ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_sh = sh; req_data = d;
    rsp_ready = (hold == 0);
    @(negedge clk);
    chk(nm, "busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      req_valid = 1'($urandom); req_op = 4'($urandom);
      req_sh = 5'($urandom); req_data = $urandom;
      @(negedge clk);
      lat++;
    end
    req_valid = 1'b0;
    chk(nm, "latency", 32'(lat), 32'(e_lat));
    chk(nm, "rsp_data", rsp_data, e_d);
    chk(nm, "rsp_err", 32'(rsp_err), 32'(e_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk(nm, "hold_valid", 32'(rsp_valid), 32'd1);
      chk(nm, "hold_data", rsp_data, e_d);
      chk(nm, "hold_err", 32'(rsp_err), 32'(e_err));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk(nm, "post_valid", 32'(rsp_valid), 32'd0);
    chk(nm, "post_ready", 32'(req_ready), 32'd1);
    chk(nm, "post_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_err;
    int          exp_lat;
    int          hold;
  } vec_t;

  vec_t tbl[11];
  logic [3:0] legal_ops[6];

  initial begin
    tbl[0]  = '{"lsl5",     4'b1010, 5'd5,  32'h0000_0001, 32'h0000_0020, 1'b0, 2, 0};
    tbl[1]  = '{"asr31",    4'b1011, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 8, 0};
    tbl[2]  = '{"ror8_bp",  4'b1100, 5'd8,  32'h1234_5678, 32'h7812_3456, 1'b0, 2, 3};
    tbl[3]  = '{"pass",     4'b1111, 5'd9,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0, 0};
    tbl[4]  = '{"lsr0",     4'b1001, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0, 0};
    tbl[5]  = '{"illegal0", 4'b0000, 5'd7,  32'h1357_9BDF, 32'h1357_9BDF, 1'b1, 0, 2};
    tbl[6]  = '{"rol4",     4'b1101, 5'd4,  32'h1234_5678, 32'h2345_6781, 1'b0, 1, 0};
    tbl[7]  = '{"lsr31",    4'b1001, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 8, 0};
    tbl[8]  = '{"ror1",     4'b1100, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b0, 1, 0};
    tbl[9]  = '{"lsl31",    4'b1010, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 8, 1};
    tbl[10] = '{"asr7pos",  4'b1011, 5'd7,  32'h7F00_0000, 32'h00FE_0000, 1'b0, 2, 0};
    legal_ops = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    foreach (tbl[i])
      run_txn(tbl[i].nm, tbl[i].op, tbl[i].sh, tbl[i].d,
              tbl[i].exp_d, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].hold);

    // Reset two cycles into a long LSR: result must vanish without a pulse.
    begin
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'b1001; req_sh = 5'd20; req_data = 32'hFFFF_0000;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid", "still_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_vals("rst_mid");
      seen = 0;
      repeat (10) begin @(negedge clk); if (rsp_valid) seen++; end
      chk("rst_mid", "no_pulse", 32'(seen), 32'd0);
      rsp_ready = 1'b0;
      run_txn("after_rst", 4'b1010, 5'd3, 32'h0000_0011, 32'h0000_0088, 1'b0, 1, 0);
    end

    // rst and req_valid together: rst wins, nothing is accepted.
    begin
      int seen;
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b1; req_op = 4'b1111; req_data = 32'hA5A5_A5A5;
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      chk("rst_req", "busy", 32'(busy), 32'd0);
      seen = 0;
      repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
      chk("rst_req", "no_pulse", 32'(seen), 32'd0);
    end

    // Random sweep over every legal op and shift amount.
    foreach (legal_ops[j]) begin
      for (int s = 0; s < 32; s++) begin
        logic [31:0] d;
        d = $urandom;
        run_txn($sformatf("rnd_op%h_sh%0d", legal_ops[j], s), legal_ops[j], 5'(s), d,
                ref_res(legal_ops[j], 5'(s), d), 1'b0,
                ref_lat(legal_ops[j], 5'(s)), int'($urandom_range(0, 2)));
      end
    end
    for (int n = 0; n < 16; n++) begin
      logic [3:0]  op;
      logic [4:0]  sh;
      logic [31:0] d;
      op = 4'($urandom); sh = 5'($urandom); d = $urandom;
      run_txn($sformatf("rnd_any%0d", n), op, sh, d, ref_res(op, sh, d),
              ref_err(op), ref_lat(op, sh), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
